pwm_dac: RTL and testbench

Audio output stage that consumes the 8-bit PCM sample stream produced by the bytebeat generator and turns it into a single-bit pulse-width-modulated signal for an external RC low-pass filter. It sits directly downstream of `bytebeat` in the top-level wrapper. It paces the generator through a valid/ready handshake, so exactly one sample is consumed per PWM period. It double-buffers each sample so the duty cycle changes only at period boundaries.

---
 rtl/pwm_dac_pkg.sv | 16 +
 rtl/pwm_dac_timebase.sv | 43 ++++
 rtl/pwm_dac.sv | 85 ++++++++
 tb/tb_pwm_dac.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_dac_pkg.sv
// Shared definitions for the PWM audio output stage.
// Default sample width, midscale start value and the sample type.
// Helper sizes the prescaler counter.
package pwm_dac_pkg;

  localparam int PWM_DAC_WIDTH    = 8;
  localparam int PWM_DAC_MIDSCALE = 1 << (PWM_DAC_WIDTH - 1);

  typedef logic [PWM_DAC_WIDTH-1:0] pwm_sample_t;

  // Prescaler counter width; never narrower than one bit so PRESCALE=1 still elaborates.
  function automatic int pre_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/pwm_dac_timebase.sv
// PWM timebase: prescaler plus free-running period counter.
// Latency: cnt/tick/boundary are decoded from registers in the same cycle.
// Backpressure: none; runs unconditionally, independent of the sample handshake.
module pwm_dac_timebase
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = PWM_DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tick_o,
  output logic             boundary_o
);

  localparam int            PW      = pre_width(PRESCALE);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Tick when the prescaler wraps; the period counter advances only on ticks.
  always_comb begin
    tick_o     = (pre_q == PRE_MAX);
    pre_d      = tick_o ? '0 : pre_q + 1'b1;
    cnt_d      = tick_o ? cnt_q + 1'b1 : cnt_q;
    boundary_o = tick_o && (cnt_q == '1);
    cnt_o      = cnt_q;
  end

  // Counter state; reset discards the current period position.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// PCM-to-PWM output stage with a one-deep pending buffer in front of the active duty register.
// Latency: a sample becomes active at the next period boundary and reaches pwm_out two cycles later.
// Backpressure: rdy is low while the pending slot is full; it reopens the cycle after a boundary drains it.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = PWM_DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pwm_dac__sample_r,
  input  logic             pwm_dac__sample_r_vld,
  output logic             pwm_dac__sample_r_rdy,
  output logic             pwm_dac__pwm_out,
  output logic             pwm_dac__underrun
);

  // Power-up duty sits at midscale so the filtered output starts at its resting level.
  localparam logic [WIDTH-1:0] MIDSCALE = WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] cnt;
  logic             tick;
  logic             boundary;
  logic             period_end;

  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_vld_q, pending_vld_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q, pwm_d;
  logic             xfer;

  pwm_dac_timebase #(
    .WIDTH    (WIDTH),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .clk        (clk),
    .reset      (reset),
    .cnt_o      (cnt),
    .tick_o     (tick),
    .boundary_o (boundary)
  );

  // A boundary is always a tick; qualifying on both keeps the swap tied to a real counter step.
  assign period_end = boundary && tick;

  // Ready depends only on the pending flag, so there is no combinational path from valid.
  assign pwm_dac__sample_r_rdy = !pending_vld_q;
  assign xfer                  = pwm_dac__sample_r_vld && !pending_vld_q;

  // Underrun: a period ends with nothing queued; a sample arriving on that same cycle does not rescue it.
  assign pwm_dac__underrun = period_end && !pending_vld_q && !reset;
  assign pwm_dac__pwm_out  = pwm_q;

  // Next-state: swap pending into active at period end, otherwise accept a new sample into pending.
  always_comb begin
    pending_d     = pending_q;
    pending_vld_d = pending_vld_q;
    active_d      = active_q;
    pwm_d         = (cnt < active_q);
    if (period_end && pending_vld_q) begin
      active_d      = pending_q;
      pending_vld_d = 1'b0;
    end else if (xfer) begin
      pending_d     = pwm_dac__sample_r;
      pending_vld_d = 1'b1;
    end
  end

  // Buffer, duty and output registers; reset drops any queued sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      pending_vld_q <= 1'b0;
      active_q      <= MIDSCALE;
      pwm_q         <= 1'b0;
    end else begin
      pending_q     <= pending_d;
      pending_vld_q <= pending_vld_d;
      active_q      <= active_d;
      pwm_q         <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac: two instances (PRESCALE 1 and 3) share stimulus.
// A per-cycle reference model checks rdy/underrun/pwm_out; directed phases pin duty counts.
// Randomized valid/sample/reset traffic closes the run.
module tb_pwm_dac;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] sample = 8'd0;
  logic       vld = 1'b0;
  logic [1:0] rdy_w, pwm_w, und_w;

  pwm_dac #(.WIDTH(8), .PRESCALE(1)) u_dut0 (
    .clk(clk), .reset(reset),
    .pwm_dac__sample_r(sample), .pwm_dac__sample_r_vld(vld),
    .pwm_dac__sample_r_rdy(rdy_w[0]), .pwm_dac__pwm_out(pwm_w[0]),
    .pwm_dac__underrun(und_w[0])
  );

  pwm_dac #(.WIDTH(8), .PRESCALE(3)) u_dut1 (
    .clk(clk), .reset(reset),
    .pwm_dac__sample_r(sample), .pwm_dac__sample_r_vld(vld),
    .pwm_dac__sample_r_rdy(rdy_w[1]), .pwm_dac__pwm_out(pwm_w[1]),
    .pwm_dac__underrun(und_w[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Period position is pure arithmetic on cycles since reset release.
  int PR[2] = '{1, 3};
  int mn[2], mact[2], mpend[2];
  bit mpv[2], mpwm[2];
  bit mvalid = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int  cntm;
        bit  bnd;
        cntm = (mn[i] / PR[i]) % 256;
        bnd  = ((mn[i] % PR[i]) == PR[i] - 1) && (cntm == 255);
        if (mvalid) begin
          chk($sformatf("rdy%0d", i), 32'(rdy_w[i]), 32'(!mpv[i]));
          chk($sformatf("underrun%0d", i), 32'(und_w[i]), 32'(bnd && !mpv[i] && !reset));
          chk($sformatf("pwm%0d", i), 32'(pwm_w[i]), 32'(mpwm[i]));
        end
        if (reset) begin
          mn[i] = 0; mact[i] = 128; mpv[i] = 1'b0; mpwm[i] = 1'b0;
        end else begin
          mpwm[i] = (cntm < mact[i]);
          if (bnd && mpv[i]) begin
            mact[i] = mpend[i]; mpv[i] = 1'b0;
          end else if (vld && !mpv[i]) begin
            mpend[i] = int'(sample); mpv[i] = 1'b1;
          end
          mn[i]++;
        end
      end
      if (reset) mvalid = 1'b1;
    end
  end

  // ---------------- statistics for directed checks ----------------
  int cyc = 0;
  bit trk = 1'b0;
  int hc0[16];
  int hc1[4];
  int f1, l1;
  int und_q[$];
  int xfer0 = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (trk && !reset) begin
        if (cyc >= 1 && pwm_w[0]) begin
          if ((cyc - 1) / 256 < 16) hc0[(cyc - 1) / 256]++;
        end
        if (und_w[0]) und_q.push_back(cyc);
        if (cyc >= 1 && pwm_w[1]) begin
          if ((cyc - 1) / 768 < 4) hc1[(cyc - 1) / 768]++;
          if ((cyc - 1) / 768 == 1) begin
            if (f1 < 0) f1 = cyc;
            l1 = cyc;
          end
        end
      end
    end
  end

  function automatic int und_at(input int k);
    return (und_q.size() > k) ? und_q[k] : -1;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    vld   = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    cyc   = 0;
    xfer0 = 0;
    for (int k = 0; k < 16; k++) hc0[k] = 0;
    for (int k = 0; k < 4; k++) hc1[k] = 0;
    f1 = -1; l1 = -1;
    und_q.delete();
  endtask

  task automatic step();
    if (vld && rdy_w[0] && !reset) xfer0++;
    @(posedge clk); #1;
    cyc++;
  endtask

  int seq[4] = '{0, 64, 255, 200};

  initial begin
    trk = 1'b1;

    // Idle after reset: midscale duty, underrun every boundary.
    do_reset();
    chk("reset_rdy", 32'(rdy_w[0]), 32'd1);
    chk("reset_pwm", 32'(pwm_w[0]), 32'd0);
    chk("reset_und", 32'(und_w[0]), 32'd0);
    repeat (1024) step();
    for (int k = 0; k < 4; k++) chk($sformatf("idle_high_p%0d", k), 32'(hc0[k]), 32'd128);
    chk("idle_und_n", 32'(und_q.size()), 32'd4);
    for (int k = 0; k < 4; k++) chk($sformatf("idle_und_at%0d", k), 32'(und_at(k)), 32'(255 + 256 * k));

    // Always-valid producer with a sample sequence.
    do_reset();
    vld = 1'b1;
    repeat (6 * 256 + 2) begin
      sample = 8'(seq[(xfer0 > 3) ? 3 : xfer0]);
      step();
    end
    vld = 1'b0;
    chk("seq_high_p0", 32'(hc0[0]), 32'd128);
    chk("seq_high_p1", 32'(hc0[1]), 32'd0);
    chk("seq_high_p2", 32'(hc0[2]), 32'd64);
    chk("seq_high_p3", 32'(hc0[3]), 32'd255);
    chk("seq_high_p4", 32'(hc0[4]), 32'd200);
    chk("seq_high_p5", 32'(hc0[5]), 32'd200);
    chk("seq_und_n", 32'(und_q.size()), 32'd0);
    chk("seq_xfers", 32'(xfer0), 32'd7);

    // Sample changes every cycle while pending is full: only the rdy-cycle value is taken.
    do_reset();
    vld = 1'b1;
    repeat (4 * 256 + 2) begin
      sample = 8'((cyc % 251) + 1);
      step();
    end
    vld = 1'b0;
    chk("hold_high_p1", 32'(hc0[1]), 32'd1);
    chk("hold_high_p2", 32'(hc0[2]), 32'd6);
    chk("hold_high_p3", 32'(hc0[3]), 32'd11);

    // PRESCALE=3 instance with sample 10.
    do_reset();
    vld = 1'b1;
    sample = 8'd10;
    repeat (2 * 768 + 2) step();
    vld = 1'b0;
    chk("pre3_high_p0", 32'(hc1[0]), 32'd384);
    chk("pre3_high_p1", 32'(hc1[1]), 32'd30);
    chk("pre3_first", 32'(f1), 32'd769);
    chk("pre3_last", 32'(l1), 32'd798);

    // Transfer on the boundary cycle: underrun still fires, no bypass.
    do_reset();
    sample = 8'd50;
    repeat (3 * 256 + 2) begin
      vld = (cyc == 255);
      step();
    end
    vld = 1'b0;
    chk("bnd_und_n", 32'(und_q.size()), 32'd2);
    chk("bnd_und_0", 32'(und_at(0)), 32'd255);
    chk("bnd_und_1", 32'(und_at(1)), 32'd767);
    chk("bnd_high_p1", 32'(hc0[1]), 32'd128);
    chk("bnd_high_p2", 32'(hc0[2]), 32'd50);

    // Reset mid-period with pending full: the queued 7 must vanish.
    do_reset();
    vld = 1'b1;
    sample = 8'd7;
    step();
    vld = 1'b0;
    repeat (99) step();
    do_reset();
    chk("mid_rst_rdy", 32'(rdy_w[0]), 32'd1);
    repeat (514) step();
    chk("mid_rst_high_p0", 32'(hc0[0]), 32'd128);
    chk("mid_rst_high_p1", 32'(hc0[1]), 32'd128);
    chk("mid_rst_und_n", 32'(und_q.size()), 32'd2);

    // Randomized traffic, checked only by the model.
    trk = 1'b0;
    do_reset();
    repeat (4000) begin
      vld    = ($urandom_range(0, 3) == 0);
      sample = 8'($urandom);
      reset  = ($urandom_range(0, 1499) == 0);
      step();
    end
    reset = 1'b0;
    vld   = 1'b0;
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
